// File: rtl/vdma_ctrl_v2.sv
// Video stream regulator between a VDMA MM2S port and a downstream sink.
// Discards beats until the upstream start-of-frame, regenerates tuser/tlast, and enforces a minimum frame period.
module vdma_ctrl_v2 #(
    parameter int TDATA_WIDTH = 64
) (
    input  logic                   s_axis_aclk,
    input  logic                   s_axis_aresetn,
    input  logic [31:0]            vdma_row,
    input  logic [31:0]            tlast_time,
    input  logic [31:0]            frame_end_time,
    input  logic [TDATA_WIDTH-1:0] s_axis_mm2s_tdata,
    input  logic                   s_axis_mm2s_tlast,
    output logic                   s_axis_mm2s_tready,
    input  logic                   s_axis_mm2s_tuser,
    input  logic                   s_axis_mm2s_tvalid,
    output logic [TDATA_WIDTH-1:0] m_axis_mm2s_tdata,
    output logic                   m_axis_mm2s_tlast,
    output logic                   m_axis_mm2s_tuser,
    output logic                   m_axis_mm2s_tvalid,
    input  logic                   m_axis_mm2s_tready
);

    // state    | meaning
    // WAIT_SOF | drop beats until an upstream tuser beat, then forward it
    // STREAM   | forward beats, count columns and lines
    // HOLD     | frame complete, stall upstream until the frame period elapses
    typedef enum logic [1:0] {WAIT_SOF, STREAM, HOLD} state_t;

    state_t      state_q, state_d;
    logic [31:0] col_cnt, col_d;
    logic [31:0] row_cnt, row_d;
    logic [31:0] frame_cnt, frame_d;
    logic [31:0] last_row;
    logic [31:0] frame_inc;
    logic        line_end;
    logic        hs;
    logic        s_tready_c, m_tvalid_c, m_tuser_c, m_tlast_c;
    logic        unused_tlast;

    assign unused_tlast      = s_axis_mm2s_tlast;
    assign m_axis_mm2s_tdata = s_axis_mm2s_tdata;

    assign last_row  = (vdma_row == 32'd0) ? 32'd0 : vdma_row - 32'd1;
    assign frame_inc = (frame_cnt == 32'hFFFF_FFFF) ? frame_cnt : frame_cnt + 32'd1;
    assign line_end  = (col_cnt == tlast_time);
    assign hs        = s_axis_mm2s_tvalid & m_axis_mm2s_tready;

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            state_q   <= WAIT_SOF;
            col_cnt   <= 32'd0;
            row_cnt   <= 32'd0;
            frame_cnt <= 32'd0;
        end else begin
            state_q   <= state_d;
            col_cnt   <= col_d;
            row_cnt   <= row_d;
            frame_cnt <= frame_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        col_d      = col_cnt;
        row_d      = row_cnt;
        frame_d    = frame_cnt;
        s_tready_c = 1'b0;
        m_tvalid_c = 1'b0;
        m_tuser_c  = 1'b0;
        m_tlast_c  = 1'b0;
        case (state_q)
            WAIT_SOF: begin
                if (s_axis_mm2s_tuser) begin
                    m_tvalid_c = s_axis_mm2s_tvalid;
                    s_tready_c = m_axis_mm2s_tready;
                    m_tuser_c  = 1'b1;
                    m_tlast_c  = line_end;
                    if (hs) begin
                        state_d = STREAM;
                        frame_d = 32'd1;
                        row_d   = 32'd0;
                        col_d   = 32'd1;
                        // single-beat lines: the SOF beat also closes line 0
                        if (line_end) begin
                            col_d = 32'd0;
                            if (last_row == 32'd0) state_d = HOLD;
                            else                   row_d   = 32'd1;
                        end
                    end
                end else begin
                    s_tready_c = 1'b1;
                end
            end
            STREAM: begin
                m_tvalid_c = s_axis_mm2s_tvalid;
                s_tready_c = m_axis_mm2s_tready;
                m_tlast_c  = line_end;
                frame_d    = frame_inc;
                if (hs) begin
                    if (line_end) begin
                        col_d = 32'd0;
                        if (row_cnt == last_row) state_d = HOLD;
                        else                     row_d   = row_cnt + 32'd1;
                    end else begin
                        col_d = col_cnt + 32'd1;
                    end
                end
            end
            HOLD: begin
                frame_d = frame_inc;
                if (frame_cnt >= frame_end_time) begin
                    state_d = WAIT_SOF;
                    frame_d = 32'd0;
                    row_d   = 32'd0;
                    col_d   = 32'd0;
                end
            end
            default: state_d = WAIT_SOF;
        endcase
    end

    // outputs are forced quiet for the whole time reset is held, not just after the edge
    assign s_axis_mm2s_tready = s_axis_aresetn & s_tready_c;
    assign m_axis_mm2s_tvalid = s_axis_aresetn & m_tvalid_c;
    assign m_axis_mm2s_tuser  = s_axis_aresetn & m_tuser_c;
    assign m_axis_mm2s_tlast  = s_axis_aresetn & m_tlast_c;

endmodule

// File: tb/tb_vdma_ctrl_v2.sv
// Self-checking bench for vdma_ctrl_v2: vector table, directed corner sequences,
// and randomized traffic against a beat-index / cycle-arithmetic reference model.
module tb_vdma_ctrl_v2;
    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  vdma_row, tlast_time, frame_end_time;
    logic [W-1:0] s_tdata;
    logic         s_tlast, s_tuser, s_tvalid, s_tready;
    logic [W-1:0] m_tdata;
    logic         m_tlast, m_tuser, m_tvalid, m_tready;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    vdma_ctrl_v2 #(.TDATA_WIDTH(W)) dut (
        .s_axis_aclk        (clk),
        .s_axis_aresetn     (rst_n),
        .vdma_row           (vdma_row),
        .tlast_time         (tlast_time),
        .frame_end_time     (frame_end_time),
        .s_axis_mm2s_tdata  (s_tdata),
        .s_axis_mm2s_tlast  (s_tlast),
        .s_axis_mm2s_tready (s_tready),
        .s_axis_mm2s_tuser  (s_tuser),
        .s_axis_mm2s_tvalid (s_tvalid),
        .m_axis_mm2s_tdata  (m_tdata),
        .m_axis_mm2s_tlast  (m_tlast),
        .m_axis_mm2s_tuser  (m_tuser),
        .m_axis_mm2s_tvalid (m_tvalid),
        .m_axis_mm2s_tready (m_tready)
    );

    typedef struct {
        logic tv, tu, mr;
        logic e_str, e_mv, e_mu, e_ml;
    } vec_t;

    vec_t tbl[25];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic tv, input logic tu, input logic mr);
        s_tvalid = tv;
        s_tuser  = tu;
        m_tready = mr;
        s_tdata  = {$urandom, $urandom};
        s_tlast  = 1'($urandom_range(0, 1));
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        repeat (2) next_cycle();
        rst_n = 1'b1;
    endtask

    task automatic set_cfg(input int rows, input int tl, input int fet);
        vdma_row       = 32'(rows);
        tlast_time     = 32'(tl);
        frame_end_time = 32'(fet);
    endtask

    task automatic run_random(input int ncyc);
        int rows, llen, nbeats, k, mode, sof_c, rel_c;
        rows   = (vdma_row == 0) ? 1 : int'(vdma_row);
        llen   = int'(tlast_time) + 1;
        nbeats = rows * llen;
        mode   = 0;   // 0 hunting SOF, 1 inside frame, 2 blocked until rel_c
        k      = 0;
        sof_c  = 0;
        rel_c  = 0;
        for (int c = 0; c < ncyc; c++) begin
            logic tv, tu, mr, e_str, e_mv, e_mu, e_ml;
            tv = ($urandom_range(0, 3) != 0);
            tu = ($urandom_range(0, 4) == 0);
            mr = ($urandom_range(0, 3) != 0);
            drive(tv, tu, mr);
            if (mode == 2 && c >= rel_c) mode = 0;
            e_str = 1'b0; e_mv = 1'b0; e_mu = 1'b0; e_ml = 1'b0;
            if (mode == 0) begin
                if (tu) begin
                    e_str = mr; e_mv = tv; e_mu = 1'b1; e_ml = (llen == 1);
                end else begin
                    e_str = 1'b1;
                end
            end else if (mode == 1) begin
                e_str = mr; e_mv = tv; e_ml = ((k % llen) == llen - 1);
            end
            @(negedge clk);
            chk("rnd_tready", s_tready, e_str);
            chk("rnd_tvalid", m_tvalid, e_mv);
            chk("rnd_tdata", m_tdata, s_tdata);
            if (e_mv) begin
                chk("rnd_tuser", m_tuser, e_mu);
                chk("rnd_tlast", m_tlast, e_ml);
            end
            if (tv && mr && e_mv) begin
                if (mode == 0) begin
                    sof_c = c;
                    k     = 0;
                end
                if (k == nbeats - 1) begin
                    mode  = 2;
                    rel_c = (c + 2 > sof_c + int'(frame_end_time) + 1) ? c + 2
                                                                      : sof_c + int'(frame_end_time) + 1;
                end else begin
                    mode = 1;
                    k++;
                end
            end
            next_cycle();
        end
    endtask

    initial begin
        int b;

        for (int i = 0; i < 25; i++) begin
            tbl[i] = '{tv: 1'b1, tu: 1'b0, mr: 1'b1, e_str: 1'b1, e_mv: 1'b0, e_mu: 1'b0, e_ml: 1'b0};
            if (i == 3) begin
                tbl[i].tu = 1'b1; tbl[i].e_mv = 1'b1; tbl[i].e_mu = 1'b1;
            end else if (i >= 4 && i <= 10) begin
                tbl[i].e_mv = 1'b1; tbl[i].e_ml = (i == 6 || i == 10);
            end else if (i >= 11 && i <= 23) begin
                tbl[i].e_str = 1'b0;
            end
        end

        set_cfg(2, 3, 20);
        rst_n = 1'b0;
        drive(1'b1, 1'b1, 1'b1);
        @(negedge clk);
        chk("rst_tready", s_tready, 1'b0);
        chk("rst_tvalid", m_tvalid, 1'b0);
        chk("rst_tuser", m_tuser, 1'b0);
        chk("rst_tlast", m_tlast, 1'b0);
        next_cycle();
        do_reset();

        // pre-SOF discard, 2x4 frame, hold until 20 cycles after SOF
        for (int i = 0; i < 25; i++) begin
            drive(tbl[i].tv, tbl[i].tu, tbl[i].mr);
            @(negedge clk);
            chk($sformatf("tbl_tready[%0d]", i), s_tready, tbl[i].e_str);
            chk($sformatf("tbl_tvalid[%0d]", i), m_tvalid, tbl[i].e_mv);
            chk($sformatf("tbl_tdata[%0d]", i), m_tdata, s_tdata);
            if (tbl[i].e_mv) begin
                chk($sformatf("tbl_tuser[%0d]", i), m_tuser, tbl[i].e_mu);
                chk($sformatf("tbl_tlast[%0d]", i), m_tlast, tbl[i].e_ml);
            end
            next_cycle();
        end

        // downstream ready toggling every cycle
        do_reset();
        b = 0;
        for (int c = 0; c < 40 && b < 8; c++) begin
            logic mr;
            mr = (c % 2 == 0);
            drive(1'b1, (b == 0), mr);
            s_tdata = 64'(b) + 64'd100;
            @(negedge clk);
            chk("tog_tready", s_tready, mr);
            chk("tog_tvalid", m_tvalid, 1'b1);
            chk("tog_tdata", m_tdata, 64'(b) + 64'd100);
            if (mr) begin
                chk($sformatf("tog_tuser[%0d]", b), m_tuser, (b == 0));
                chk($sformatf("tog_tlast[%0d]", b), m_tlast, (b == 3 || b == 7));
                b++;
            end
            next_cycle();
        end
        chk("tog_beats", 64'(b), 64'd8);
        drive(1'b1, 1'b0, 1'b1);
        @(negedge clk);
        chk("tog_hold_tready", s_tready, 1'b0);
        chk("tog_hold_tvalid", m_tvalid, 1'b0);
        next_cycle();

        // single-beat frames with no minimum period
        set_cfg(1, 0, 0);
        do_reset();
        for (int c = 0; c < 10; c++) begin
            drive(1'b1, 1'b1, 1'b1);
            @(negedge clk);
            chk($sformatf("one_tready[%0d]", c), s_tready, (c % 2 == 0));
            chk($sformatf("one_tvalid[%0d]", c), m_tvalid, (c % 2 == 0));
            if (c % 2 == 0) begin
                chk($sformatf("one_tuser[%0d]", c), m_tuser, 1'b1);
                chk($sformatf("one_tlast[%0d]", c), m_tlast, 1'b1);
            end
            next_cycle();
        end

        // reset in the middle of a frame
        set_cfg(2, 3, 20);
        do_reset();
        for (int c = 0; c < 5; c++) begin
            drive(1'b1, (c == 0), 1'b1);
            @(negedge clk);
            chk("mid_tvalid", m_tvalid, 1'b1);
            next_cycle();
        end
        rst_n = 1'b0;
        drive(1'b1, 1'b1, 1'b1);
        @(negedge clk);
        chk("mid_rst_tready", s_tready, 1'b0);
        chk("mid_rst_tvalid", m_tvalid, 1'b0);
        chk("mid_rst_tuser", m_tuser, 1'b0);
        chk("mid_rst_tlast", m_tlast, 1'b0);
        next_cycle();
        rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            drive(1'b1, 1'b0, 1'b1);
            @(negedge clk);
            chk("resync_drop_tready", s_tready, 1'b1);
            chk("resync_drop_tvalid", m_tvalid, 1'b0);
            next_cycle();
        end
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, (c == 0), 1'b1);
            @(negedge clk);
            chk($sformatf("resync_tvalid[%0d]", c), m_tvalid, 1'b1);
            chk($sformatf("resync_tuser[%0d]", c), m_tuser, (c == 0));
            chk($sformatf("resync_tlast[%0d]", c), m_tlast, (c == 3));
            next_cycle();
        end

        // randomized traffic across several configurations
        for (int seg = 0; seg < 5; seg++) begin
            set_cfg($urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 40));
            do_reset();
            run_random(300);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/vdma_ctrl_v2.md
VDMA_CTRL_V2 -- requirements
Module: vdma_ctrl_v2

Interface
REQ-001 Parameter: TDATA_WIDTH, default 64, width of the stream data buses.
REQ-002 s_axis_aclk  in  1  single clock; all logic rising-edge.
REQ-003 s_axis_aresetn  in  1  reset; asynchronous, active-low.
REQ-004 vdma_row  in  32  lines per frame; value 0 SHALL be treated as 1.
REQ-005 tlast_time  in  32  index of last beat in a line; line length = tlast_time+1 beats.
REQ-006 frame_end_time  in  32  minimum frame period in clock cycles, measured from the SOF beat.
REQ-007 s_axis_mm2s_tdata  in  TDATA_WIDTH  upstream (VDMA MM2S) data.
REQ-008 s_axis_mm2s_tlast  in  1  upstream end-of-line; ignored.
REQ-009 s_axis_mm2s_tready  out  1  ready to upstream.
REQ-010 s_axis_mm2s_tuser  in  1  upstream start-of-frame.
REQ-011 s_axis_mm2s_tvalid  in  1  upstream valid.
REQ-012 m_axis_mm2s_tdata  out  TDATA_WIDTH  downstream data.
REQ-013 m_axis_mm2s_tlast  out  1  regenerated end-of-line.
REQ-014 m_axis_mm2s_tuser  out  1  regenerated start-of-frame.
REQ-015 m_axis_mm2s_tvalid  out  1  downstream valid.
REQ-016 m_axis_mm2s_tready  in  1  downstream ready.

Function
REQ-017 Data path SHALL be combinational, zero latency: m_tdata = s_tdata always; handshake = valid & ready on the respective port.
REQ-018 States: WAIT_SOF, STREAM, HOLD; beat counter col_cnt, line counter row_cnt, frame timer frame_cnt (all 32-bit).
REQ-019 WAIT_SOF: beats with s_tuser=0 SHALL be discarded (s_tready=1, m_tvalid=0); a beat with s_tuser=1 SHALL be forwarded (m_tvalid=s_tvalid, s_tready=m_tready).
REQ-020 On the SOF handshake: go to STREAM, frame_cnt<=1, col_cnt<=1, row_cnt<=0, except when tlast_time=0, where that beat closes line 0 under REQ-024/REQ-025.
REQ-021 STREAM: m_tvalid=s_tvalid, s_tready=m_tready; col_cnt increments per downstream handshake.
REQ-022 m_tuser SHALL be 1 only on the first beat of a frame (the SOF beat), 0 otherwise.
REQ-023 m_tlast SHALL be 1 when col_cnt==tlast_time (combinational, includes the SOF beat when tlast_time=0).
REQ-024 On a handshake with m_tlast=1: col_cnt<=0; if row_cnt==max(vdma_row,1)-1, go to HOLD, else row_cnt+1.
REQ-025 Upstream s_tuser SHALL be ignored in STREAM and HOLD; upstream s_tlast is always ignored.
REQ-026 HOLD: s_tready=0, m_tvalid=0; exit to WAIT_SOF in the cycle after frame_cnt>=frame_end_time.
REQ-027 frame_cnt SHALL increment every cycle outside WAIT_SOF and saturate at 2^32-1.
REQ-028 If the last line ends with frame_cnt already >= frame_end_time, HOLD SHALL last exactly one cycle.
REQ-029 Config inputs SHALL be quasi-static; changes take effect at the next comparison.

Reset
REQ-030 While s_axis_aresetn=0: state WAIT_SOF, all counters 0, s_tready=0, m_tvalid=0, m_tlast=0, m_tuser=0.
REQ-031 Reset asserted mid-frame SHALL abort the frame immediately; after release, the block resyncs on the next upstream tuser beat.

Verification
REQ-032 vdma_row=2, tlast_time=3, frame_end_time=20, ready=1, continuous valid with SOF -> 8 beats out, tuser on beat 0, tlast on beats 3 and 7, then s_tready=0 until cycle 20 after SOF.
REQ-033 Three non-tuser beats precede SOF -> all three accepted (s_tready=1), none forwarded (m_tvalid=0); SOF beat forwarded with tuser=1.
REQ-034 m_tready toggles 1/0 every cycle -> beat order, tlast positions (beats 3, 7) and tuser position (beat 0) unchanged; no beat lost or duplicated.
REQ-035 frame_end_time=0, vdma_row=1, tlast_time=0 -> every SOF beat is output with tuser=1 and tlast=1; HOLD lasts 1 cycle.
REQ-036 Reset pulsed after 5 beats of a frame -> outputs 0 during reset; next frame output begins only at the next tuser beat, counters restart at 0.
